// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings common to uart_tx/uart_rx,
// frame width and the default bit period.
package uart_pkg;

  localparam logic [2:0] s_IDLE    = 3'b000;
  localparam logic [2:0] s_START   = 3'b001;
  localparam logic [2:0] s_DATA    = 3'b010;
  localparam logic [2:0] s_STOP    = 3'b011;
  localparam logic [2:0] s_CLEANUP = 3'b100;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 10415;

  typedef enum logic [2:0] {
    ST_IDLE    = s_IDLE,
    ST_START   = s_START,
    ST_DATA    = s_DATA,
    ST_STOP    = s_STOP,
    ST_CLEANUP = s_CLEANUP
  } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Serial input and received-byte outputs of the UART receiver.
// master = receiver side, slave = line driver / byte consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Rx_Frame_Err;
  logic                 o_Rx_Active;

  modport master (
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Rx_Frame_Err,
    output o_Rx_Active
  );

  modport slave (
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Rx_Frame_Err,
    input  o_Rx_Active
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus one delay
// flop for falling-edge detection. All flops reset to the idle level (1).
module uart_rx_sync (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Rx_Serial,
  output logic o_Rx_S,
  output logic o_Fall
);

  logic r_Meta;
  logic r_Rx_S;
  logic r_Rx_D;

  // Synchroniser chain and edge-detect delay
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Meta <= 1'b1;
      r_Rx_S <= 1'b1;
      r_Rx_D <= 1'b1;
    end else begin
      r_Meta <= i_Rx_Serial;
      r_Rx_S <= r_Meta;
      r_Rx_D <= r_Rx_S;
    end
  end

  assign o_Rx_S = r_Rx_S;
  assign o_Fall = r_Rx_D & ~r_Rx_S;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, mid-bit sampling of start, data and stop
// bits. Emits a one-cycle valid strobe per good byte, or a framing-error strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic      i_Clock,
  input  logic      i_Reset,
  uart_rx_if.master rx_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [31:0] HALF_CNT = 32'((CLKS_PER_BIT - 1) / 2);
  localparam logic [31:0] LAST_CNT = 32'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t            r_State;
  rx_state_t            w_State_Next;
  logic [CNT_W-1:0]     r_Clk_Count;
  logic [CNT_W-1:0]     w_Cnt_Next;
  logic [IDX_W-1:0]     r_Bit_Idx;
  logic [IDX_W-1:0]     w_Idx_Next;
  logic [DATA_BITS-1:0] r_Shift;
  logic [DATA_BITS-1:0] w_Shift_Next;
  logic [DATA_BITS-1:0] r_Rx_Byte;
  logic [DATA_BITS-1:0] w_Byte_Next;
  logic                 r_Rx_DV;
  logic                 w_DV_Next;
  logic                 r_Frame_Err;
  logic                 w_FE_Next;
  logic                 r_Rx_Active;
  logic                 w_Active_Next;
  logic                 w_Rx_S;
  logic                 w_Fall;
  logic [31:0]          w_Cnt_Ext;

  uart_rx_sync u_sync (
    .i_Clock     (i_Clock),
    .i_Reset     (i_Reset),
    .i_Rx_Serial (rx_if.i_Rx_Serial),
    .o_Rx_S      (w_Rx_S),
    .o_Fall      (w_Fall)
  );

  // Zero-extend so bit-period compares use the untruncated parameter values
  assign w_Cnt_Ext = 32'(r_Clk_Count);

  // Next-state, counters, shift register and output strobes
  always_comb begin
    w_State_Next = r_State;
    w_Cnt_Next   = r_Clk_Count;
    w_Idx_Next   = r_Bit_Idx;
    w_Shift_Next = r_Shift;
    w_Byte_Next  = r_Rx_Byte;
    w_DV_Next    = 1'b0;
    w_FE_Next    = 1'b0;
    case (r_State)
      ST_IDLE: begin
        w_Cnt_Next = {CNT_W{1'b0}};
        w_Idx_Next = {IDX_W{1'b0}};
        if (w_Fall) begin
          w_State_Next = ST_START;
        end else begin
          w_State_Next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_Cnt_Ext == HALF_CNT) begin
          w_Cnt_Next = {CNT_W{1'b0}};
          if (!w_Rx_S) begin
            w_State_Next = ST_DATA;
          end else begin
            w_State_Next = ST_IDLE;
          end
        end else begin
          w_Cnt_Next = r_Clk_Count + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (w_Cnt_Ext == LAST_CNT) begin
          w_Cnt_Next              = {CNT_W{1'b0}};
          w_Shift_Next[r_Bit_Idx] = w_Rx_S;
          if (r_Bit_Idx < LAST_IDX) begin
            w_Idx_Next = r_Bit_Idx + IDX_W'(1);
          end else begin
            w_Idx_Next   = {IDX_W{1'b0}};
            w_State_Next = ST_STOP;
          end
        end else begin
          w_Cnt_Next = r_Clk_Count + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (w_Cnt_Ext == LAST_CNT) begin
          w_Cnt_Next   = {CNT_W{1'b0}};
          w_State_Next = ST_CLEANUP;
          if (w_Rx_S) begin
            w_Byte_Next = r_Shift;
            w_DV_Next   = 1'b1;
          end else begin
            w_FE_Next = 1'b1;
          end
        end else begin
          w_Cnt_Next = r_Clk_Count + CNT_W'(1);
        end
      end
      ST_CLEANUP: begin
        w_State_Next = ST_IDLE;
      end
      default: begin
        w_State_Next = ST_IDLE;
        w_Cnt_Next   = {CNT_W{1'b0}};
        w_Idx_Next   = {IDX_W{1'b0}};
      end
    endcase
    w_Active_Next = (w_State_Next == ST_START) || (w_State_Next == ST_DATA) ||
                    (w_State_Next == ST_STOP);
  end

  // State and registered outputs
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State     <= ST_IDLE;
      r_Clk_Count <= {CNT_W{1'b0}};
      r_Bit_Idx   <= {IDX_W{1'b0}};
      r_Shift     <= {DATA_BITS{1'b0}};
      r_Rx_Byte   <= {DATA_BITS{1'b0}};
      r_Rx_DV     <= 1'b0;
      r_Frame_Err <= 1'b0;
      r_Rx_Active <= 1'b0;
    end else begin
      r_State     <= w_State_Next;
      r_Clk_Count <= w_Cnt_Next;
      r_Bit_Idx   <= w_Idx_Next;
      r_Shift     <= w_Shift_Next;
      r_Rx_Byte   <= w_Byte_Next;
      r_Rx_DV     <= w_DV_Next;
      r_Frame_Err <= w_FE_Next;
      r_Rx_Active <= w_Active_Next;
    end
  end

  assign rx_if.o_Rx_DV        = r_Rx_DV;
  assign rx_if.o_Rx_Byte      = r_Rx_Byte;
  assign rx_if.o_Rx_Frame_Err = r_Frame_Err;
  assign rx_if.o_Rx_Active    = r_Rx_Active;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .rx_if   (u_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int         dv_cnt = 0;
  int         fe_cnt = 0;
  int         dv_wide = 0;
  int         fe_wide = 0;
  int         overlap = 0;
  logic       prev_dv = 1'b0;
  logic       prev_fe = 1'b0;
  logic [7:0] dv_bytes[$];
  int         dv_cyc[$];

  // Strobe monitor sampled on the inactive edge
  always @(negedge clk) begin
    if (u_if.o_Rx_DV === 1'b1) begin
      dv_cnt <= dv_cnt + 1;
      dv_bytes.push_back(u_if.o_Rx_Byte);
      dv_cyc.push_back(cyc);
      if (prev_dv) dv_wide <= dv_wide + 1;
    end
    if (u_if.o_Rx_Frame_Err === 1'b1) begin
      fe_cnt <= fe_cnt + 1;
      if (prev_fe) fe_wide <= fe_wide + 1;
    end
    if (u_if.o_Rx_DV === 1'b1 && u_if.o_Rx_Frame_Err === 1'b1) overlap <= overlap + 1;
    prev_dv <= u_if.o_Rx_DV;
    prev_fe <= u_if.o_Rx_Frame_Err;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    u_if.i_Rx_Serial = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    u_if.i_Rx_Serial = 1'b1;
    tick(3);
    n_tests++;
    if (u_if.o_Rx_DV !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", u_if.o_Rx_DV); end
    n_tests++;
    if (u_if.o_Rx_Frame_Err !== 1'b0) begin n_fail++; $display("FAIL reset_fe: got %b expected 0", u_if.o_Rx_Frame_Err); end
    n_tests++;
    if (u_if.o_Rx_Active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", u_if.o_Rx_Active); end
    n_tests++;
    if (u_if.o_Rx_Byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", u_if.o_Rx_Byte); end
    rst = 1'b0;
    tick(4);
    n_tests++;
    if (u_if.o_Rx_Active !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %b expected 0", u_if.o_Rx_Active); end
  endtask

  task automatic test_single;
    int bd, bf, qi, t0, lat;
    bd = dv_cnt; bf = fe_cnt; qi = dv_bytes.size(); t0 = cyc;
    send_frame(8'h37, 1'b1);
    tick(2 * CPB);
    n_tests++;
    if (dv_cnt - bd !== 1) begin n_fail++; $display("FAIL single_dv_count: got %0d expected 1", dv_cnt - bd); end
    n_tests++;
    if (dv_bytes.size() <= qi || dv_bytes[qi] !== 8'h37) begin
      n_fail++; $display("FAIL single_dv_byte: got %h expected 37", u_if.o_Rx_Byte);
    end
    n_tests++;
    lat = (dv_cyc.size() > qi) ? dv_cyc[qi] - t0 : -1;
    if (lat < 153 || lat > 155) begin n_fail++; $display("FAIL single_latency: got %0d expected 154+-1", lat); end
    n_tests++;
    if (fe_cnt - bf !== 0) begin n_fail++; $display("FAIL single_fe: got %0d expected 0", fe_cnt - bf); end
    n_tests++;
    if (u_if.o_Rx_Byte !== 8'h37) begin n_fail++; $display("FAIL single_byte_hold: got %h expected 37", u_if.o_Rx_Byte); end
    n_tests++;
    if (u_if.o_Rx_Active !== 1'b0) begin n_fail++; $display("FAIL single_active_end: got %b expected 0", u_if.o_Rx_Active); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_b[3];
    int bd, qi;
    exp_b[0] = 8'hA5; exp_b[1] = 8'h00; exp_b[2] = 8'hFF;
    bd = dv_cnt; qi = dv_bytes.size();
    for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1);
    tick(2 * CPB);
    n_tests++;
    if (dv_cnt - bd !== 3) begin n_fail++; $display("FAIL b2b_dv_count: got %0d expected 3", dv_cnt - bd); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (dv_bytes.size() <= qi + i || dv_bytes[qi+i] !== exp_b[i]) begin
        n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i,
                           (dv_bytes.size() > qi + i) ? dv_bytes[qi+i] : 8'hxx, exp_b[i]);
      end
    end
    for (int i = 1; i < 3; i++) begin
      int sp;
      sp = (dv_cyc.size() > qi + i) ? dv_cyc[qi+i] - dv_cyc[qi+i-1] : -1;
      n_tests++;
      if (sp < 159 || sp > 161) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d expected 160+-1", i, sp); end
    end
  endtask

  task automatic test_glitch;
    int bd, bf, act;
    bd = dv_cnt; bf = fe_cnt; act = 0;
    u_if.i_Rx_Serial = 1'b0;
    for (int i = 0; i < 52; i++) begin
      tick(1);
      if (i == 3) u_if.i_Rx_Serial = 1'b1;
      if (u_if.o_Rx_Active === 1'b1) act++;
    end
    n_tests++;
    if (act < 1 || act > 8) begin n_fail++; $display("FAIL glitch_active_len: got %0d expected 1..8", act); end
    n_tests++;
    if (dv_cnt - bd !== 0) begin n_fail++; $display("FAIL glitch_dv: got %0d expected 0", dv_cnt - bd); end
    n_tests++;
    if (fe_cnt - bf !== 0) begin n_fail++; $display("FAIL glitch_fe: got %0d expected 0", fe_cnt - bf); end
    n_tests++;
    if (u_if.o_Rx_Active !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", u_if.o_Rx_Active); end
  endtask

  task automatic test_frame_err;
    int bd, bf;
    bd = dv_cnt; bf = fe_cnt;
    send_frame(8'h5A, 1'b0);
    u_if.i_Rx_Serial = 1'b1;
    tick(3 * CPB);
    n_tests++;
    if (fe_cnt - bf !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", fe_cnt - bf); end
    n_tests++;
    if (dv_cnt - bd !== 0) begin n_fail++; $display("FAIL ferr_dv: got %0d expected 0", dv_cnt - bd); end
    n_tests++;
    if (u_if.o_Rx_Byte !== 8'hFF) begin n_fail++; $display("FAIL ferr_byte_hold: got %h expected FF", u_if.o_Rx_Byte); end
  endtask

  task automatic test_break;
    int bd, bf, qi;
    bd = dv_cnt; bf = fe_cnt; qi = dv_bytes.size();
    u_if.i_Rx_Serial = 1'b0;
    tick(40 * CPB);
    n_tests++;
    if (fe_cnt - bf !== 1) begin n_fail++; $display("FAIL break_fe: got %0d expected 1", fe_cnt - bf); end
    n_tests++;
    if (dv_cnt - bd !== 0) begin n_fail++; $display("FAIL break_dv: got %0d expected 0", dv_cnt - bd); end
    u_if.i_Rx_Serial = 1'b1;
    tick(2 * CPB);
    send_frame(8'h81, 1'b1);
    tick(2 * CPB);
    n_tests++;
    if (dv_cnt - bd !== 1 || dv_bytes.size() <= qi || dv_bytes[qi] !== 8'h81) begin
      n_fail++; $display("FAIL break_then_frame: got %0d pulses byte %h expected 1 pulse byte 81", dv_cnt - bd, u_if.o_Rx_Byte);
    end
    n_tests++;
    if (fe_cnt - bf !== 1) begin n_fail++; $display("FAIL break_fe_total: got %0d expected 1", fe_cnt - bf); end
  endtask

  task automatic test_reset_abort;
    int bd, bf, qi;
    bd = dv_cnt; bf = fe_cnt; qi = dv_bytes.size();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    u_if.i_Rx_Serial = 1'b0;
    tick(CPB / 2);
    u_if.i_Rx_Serial = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_tests++;
    if (u_if.o_Rx_Byte !== 8'h00) begin n_fail++; $display("FAIL abort_byte_reset: got %h expected 00", u_if.o_Rx_Byte); end
    n_tests++;
    if (u_if.o_Rx_Active !== 1'b0) begin n_fail++; $display("FAIL abort_active: got %b expected 0", u_if.o_Rx_Active); end
    tick(12 * CPB);
    n_tests++;
    if (dv_cnt - bd !== 0 || fe_cnt - bf !== 0) begin
      n_fail++; $display("FAIL abort_strobes: got dv %0d fe %0d expected 0 0", dv_cnt - bd, fe_cnt - bf);
    end
    send_frame(8'h3C, 1'b1);
    tick(2 * CPB);
    n_tests++;
    if (dv_cnt - bd !== 1 || dv_bytes.size() <= qi || dv_bytes[qi] !== 8'h3C) begin
      n_fail++; $display("FAIL abort_next_frame: got %0d pulses byte %h expected 1 pulse byte 3C", dv_cnt - bd, u_if.o_Rx_Byte);
    end
  endtask

  task automatic test_strobe_shape;
    n_tests++;
    if (dv_wide !== 0 || fe_wide !== 0) begin
      n_fail++; $display("FAIL strobe_width: got dv_wide %0d fe_wide %0d expected 0 0", dv_wide, fe_wide);
    end
    n_tests++;
    if (overlap !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d expected 0", overlap); end
  endtask

  initial begin
    u_if.i_Rx_Serial = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_abort();
    test_strobe_shape();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
